ps2_key_ctrl: RTL and testbench

Synchronous PS/2 keyboard front end and scan-code sequencer for the Pac-Man top level. It samples the raw keyboard clock and data pins in the `clk50` domain and assembles 11-bit frames with start, parity and stop checking. It folds `E0`/`F0` prefixes into key events, queues those events for the game logic, and maintains a held-arrow-key direction bitmap for the player-movement logic.

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_event_fifo.sv | 58 +++++
 rtl/ps2_key_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end:
// scan codes, frame-FSM state encoding and the queued-event layout.
package ps2_pkg;

  // Scan codes the decoder and direction map care about.
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Bit positions inside dir, order {up, down, left, right}.
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  // Event layout: {ext, brk, code}, ext in the MSB.
  localparam int EV_CODE_W = 8;
  localparam int EV_W      = EV_CODE_W + 2;

  typedef struct packed {
    logic                 ext;
    logic                 brk;
    logic [EV_CODE_W-1:0] code;
  } ps2_ev_t;

  // Frame receiver states; one PS/2 frame is start, 8 data, parity, stop.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through event queue. dout always shows the head entry
// (zero when empty). A push into a full queue is accepted only when a pop
// frees a slot on the same edge; a pop on an empty queue is ignored.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = EV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because dout is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard front end: pin synchronizers, 11-bit frame receiver with
// parity/stop/timeout checking, E0/F0 prefix decoder, held-arrow direction
// map and an event queue for the game logic.
//
// Event handshake: ev_valid is high whenever the queue holds an entry and
// ev_code/ev_ext/ev_break show that entry; the entry is consumed at the
// clk50 edge where ev_valid && ev_ready, and ev_ready without ev_valid
// has no effect. ev_valid never depends on ev_ready.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 3000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       kclk,
  input  logic       kin,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [3:0] dir,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYC);

  // Conditioned pins.
  logic kclk_s1, kclk_s2, kclk_prev;
  logic kin_s1, kin_s2, kin_d;
  logic fall;

  // Frame receiver; frame_state is the FSM state seen by checkers.
  frame_state_t  frame_state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] idle_cnt;
  logic          byte_valid;
  logic [7:0]    byte_data;

  // Decoder.
  logic    ext_flag;
  logic    brk_flag;
  logic    dec_push;
  ps2_ev_t dec_ev;

  // Queue.
  logic [EV_W-1:0] fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  ps2_ev_t         head;

  // Two-flop synchronizers plus an edge register; kin is delayed one more
  // flop so it lines up with the registered falling-edge strobe.
  always_ff @(posedge clk50) begin
    if (!reset) begin
      kclk_s1   <= 1'b1;
      kclk_s2   <= 1'b1;
      kclk_prev <= 1'b1;
      kin_s1    <= 1'b1;
      kin_s2    <= 1'b1;
      kin_d     <= 1'b1;
      fall      <= 1'b0;
    end else begin
      kclk_s1   <= kclk;
      kclk_s2   <= kclk_s1;
      kclk_prev <= kclk_s2;
      fall      <= kclk_prev & ~kclk_s2;
      kin_s1    <= kin;
      kin_s2    <= kin_s1;
      kin_d     <= kin_s2;
    end
  end

  // Frame FSM with inactivity timeout; advances only on kclk falling edges.
  always_ff @(posedge clk50) begin
    if (!reset) begin
      frame_state <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      idle_cnt    <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      frame_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        case (frame_state)
          ST_IDLE: begin
            if (!kin_d) begin
              frame_state <= ST_DATA;
              bit_cnt     <= '0;
            end
          end
          ST_DATA: begin
            shreg <= {kin_d, shreg[7:1]};
            if (bit_cnt == 3'd7) frame_state <= ST_PARITY;
            else                 bit_cnt     <= bit_cnt + 3'd1;
          end
          ST_PARITY: begin
            par_bit     <= kin_d;
            frame_state <= ST_STOP;
          end
          ST_STOP: begin
            frame_state <= ST_IDLE;
            if ((^{shreg, par_bit}) && kin_d) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: frame_state <= ST_IDLE;
        endcase
      end else if (frame_state == ST_IDLE) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TO_LIMIT) begin
        // Keyboard went quiet mid-frame: drop the partial byte.
        frame_state <= ST_IDLE;
        idle_cnt    <= '0;
        shreg       <= '0;
        frame_err   <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

  // Prefix decoder: E0/F0 arm flags, any other byte emits one event.
  always_ff @(posedge clk50) begin
    if (!reset) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      dec_push <= 1'b0;
      dec_ev   <= '0;
    end else begin
      dec_push <= 1'b0;
      if (byte_valid) begin
        if (byte_data == SC_EXT) begin
          ext_flag <= 1'b1;
        end else if (byte_data == SC_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          dec_push <= 1'b1;
          dec_ev   <= '{ext: ext_flag, brk: brk_flag, code: byte_data};
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

  // Held-arrow map; tracks every decoded event, queued or dropped.
  always_ff @(posedge clk50) begin
    if (!reset) begin
      dir <= '0;
    end else if (dec_push && dec_ev.ext) begin
      case (dec_ev.code)
        SC_UP:    dir[DIR_UP]    <= !dec_ev.brk;
        SC_DOWN:  dir[DIR_DOWN]  <= !dec_ev.brk;
        SC_LEFT:  dir[DIR_LEFT]  <= !dec_ev.brk;
        SC_RIGHT: dir[DIR_RIGHT] <= !dec_ev.brk;
        default:  ;
      endcase
    end
  end

  // Drop strobe: a push meets a full queue that is not being popped.
  always_ff @(posedge clk50) begin
    if (!reset) overflow <= 1'b0;
    else        overflow <= dec_push && fifo_full && !(ev_ready && ev_valid);
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EV_W)
  ) u_fifo (
    .clk   (clk50),
    .reset (reset),
    .push  (dec_push),
    .din   (dec_ev),
    .pop   (ev_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head     = ps2_ev_t'(fifo_dout);
  assign ev_valid = !fifo_empty;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_break = head.brk;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Testbench for ps2_key_ctrl: bit-banged PS/2 frames, a queue-based
// reference model of the key-event stream, and per-scenario checks.
module tb_ps2_key_ctrl;

  localparam int TIMEOUT_CYC = 3000;
  localparam int FIFO_DEPTH  = 4;
  localparam int HALF        = 20;

  // ---------------- clock / reset ----------------
  logic       clk50    = 1'b0;
  logic       reset    = 1'b0;
  logic       kclk     = 1'b1;
  logic       kin      = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [3:0] dir;
  logic       frame_err;
  logic       overflow;

  always #10 clk50 = ~clk50;

  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  ps2_key_ctrl #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk50     (clk50),
    .reset     (reset),
    .kclk      (kclk),
    .kin       (kin),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_break  (ev_break),
    .dir       (dir),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    #1_800_000;
    $display("FAIL watchdog: bench still running at cycle %0d, required to finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- pulse monitor ----------------
  int   err_pulses = 0, err_wide = 0, err_cyc = -1;
  int   ovf_pulses = 0, ovf_wide = 0;
  int   valid_rise_cyc = -1, dir_chg_cyc = -1;
  logic prev_err = 1'b0, prev_ovf = 1'b0, prev_valid = 1'b0;
  logic [3:0] prev_dir = 4'h0;

  always @(negedge clk50) begin
    if (frame_err === 1'b1) begin
      err_pulses++;
      err_cyc = cyc;
      if (prev_err) err_wide++;
    end
    if (overflow === 1'b1) begin
      ovf_pulses++;
      if (prev_ovf) ovf_wide++;
    end
    if (ev_valid === 1'b1 && !prev_valid) valid_rise_cyc = cyc;
    if (dir !== prev_dir) dir_chg_cyc = cyc;
    prev_err   = frame_err;
    prev_ovf   = overflow;
    prev_valid = ev_valid;
    prev_dir   = dir;
  end

  // ---------------- reference model ----------------
  // Keyboard semantics: prefixes arm flags, other bytes become events
  // {ext, brk, code}; the queue holds at most FIFO_DEPTH events.
  logic [9:0] exp_q[$];
  logic       m_ext = 1'b0, m_brk = 1'b0;
  logic [3:0] m_dir = 4'h0;
  int         exp_err = 0, exp_ovf = 0;

  task automatic model_byte(input logic [7:0] b);
    int idx;
    idx = -1;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (m_ext) begin
        case (b)
          8'h75:   idx = 3;
          8'h72:   idx = 2;
          8'h6B:   idx = 1;
          8'h74:   idx = 0;
          default: idx = -1;
        endcase
        if (idx >= 0) m_dir[idx] = !m_brk;
      end
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else exp_ovf++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_dir = 4'h0;
  endtask

  // ---------------- drivers ----------------
  int last_fall_cyc = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  // {stop, parity, data[7:0], start}; odd parity over data+parity.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    logic s;
    p = ~(^b) ^ bad_par;
    s = ~bad_stop;
    return {s, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kin = bits[i];
      wait_cyc(HALF);
      kclk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(HALF);
      kclk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(frame_bits(b, bad_par, bad_stop), 11);
    if (bad_par || bad_stop) exp_err++;
    else model_byte(b);
    wait_cyc(4);
  endtask

  task automatic pop_event(output logic [9:0] got, output logic vld);
    @(negedge clk50);
    vld = ev_valid;
    got = {ev_ext, ev_break, ev_code};
    ev_ready = 1'b1;
    @(posedge clk50);
    #1 ev_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    wait_cyc(5);
    @(negedge clk50);
    checks++;
    if ({ev_valid, ev_ext, ev_break, ev_code, dir, frame_err, overflow} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b ext=%b brk=%b code=%h dir=%b err=%b ovf=%b, required all 0",
               ev_valid, ev_ext, ev_break, ev_code, dir, frame_err, overflow);
    end
    wait_cyc(1);
    reset = 1'b1;
    wait_cyc(5);
    @(negedge clk50);
    checks++;
    if ({ev_valid, dir, frame_err, overflow} !== 7'h0) begin
      errors++;
      $display("FAIL after_reset_idle: got valid=%b dir=%b err=%b ovf=%b, required all 0",
               ev_valid, dir, frame_err, overflow);
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] got, exp;
    logic       vld;
    // pops on an empty queue must not disturb it
    wait_cyc(1);
    ev_ready = 1'b1;
    wait_cyc(3);
    ev_ready = 1'b0;
    send_frame(8'h1C, 0, 0);
    checks++;
    if (valid_rise_cyc !== last_fall_cyc + 6) begin
      errors++;
      $display("FAIL single_valid_latency: ev_valid rose at cycle %0d, required %0d", valid_rise_cyc, last_fall_cyc + 6);
    end
    exp = exp_q.pop_front();
    pop_event(got, vld);
    checks++;
    if (!vld || got !== exp) begin
      errors++;
      $display("FAIL single_event: got valid=%b ev=%h, required valid=1 ev=%h", vld, got, exp);
    end
    @(negedge clk50);
    checks++;
    if (ev_valid !== 1'b0 || err_pulses !== exp_err) begin
      errors++;
      $display("FAIL single_after_pop: got valid=%b err_pulses=%0d, required valid=0 err_pulses=%0d", ev_valid, err_pulses, exp_err);
    end
  endtask

  task automatic test_arrows();
    logic [9:0] got, exp;
    logic       vld;
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    checks++;
    if (dir !== m_dir || dir_chg_cyc !== last_fall_cyc + 6) begin
      errors++;
      $display("FAIL arrow_make: got dir=%b at cycle %0d, required dir=%b at cycle %0d", dir, dir_chg_cyc, m_dir, last_fall_cyc + 6);
    end
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    checks++;
    if (dir !== m_dir) begin
      errors++;
      $display("FAIL arrow_break: got dir=%b, required %b", dir, m_dir);
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      pop_event(got, vld);
      checks++;
      if (!vld || got !== exp) begin
        errors++;
        $display("FAIL arrow_event: got valid=%b ev=%h, required valid=1 ev=%h", vld, got, exp);
      end
    end
  endtask

  task automatic test_frame_errors();
    for (int k = 0; k < 2; k++) begin
      send_frame(8'h1C, (k == 0), (k == 1));
      checks++;
      if (err_pulses !== exp_err || err_cyc !== last_fall_cyc + 4 || ev_valid !== 1'b0) begin
        errors++;
        $display("FAIL frame_err_%0d: got pulses=%0d at cycle %0d valid=%b, required pulses=%0d at cycle %0d valid=0",
                 k, err_pulses, err_cyc, ev_valid, exp_err, last_fall_cyc + 4);
      end
    end
  endtask

  task automatic test_timeout();
    logic [10:0] bits;
    logic [9:0]  got, exp;
    logic        vld;
    int          fall_at;
    bits = frame_bits(8'h5A, 0, 0);
    send_bits(bits, 4);
    kin = bits[4];
    wait_cyc(HALF);
    kclk = 1'b0;
    fall_at = cyc;
    wait_cyc(TIMEOUT_CYC + 100);
    kclk = 1'b1;
    wait_cyc(HALF);
    exp_err++;
    checks++;
    if (err_pulses !== exp_err || err_cyc < fall_at + TIMEOUT_CYC || err_cyc > fall_at + TIMEOUT_CYC + 8) begin
      errors++;
      $display("FAIL timeout_err: got pulses=%0d last at cycle %0d, required pulses=%0d within [%0d,%0d]",
               err_pulses, err_cyc, exp_err, fall_at + TIMEOUT_CYC, fall_at + TIMEOUT_CYC + 8);
    end
    send_frame(8'h29, 0, 0);
    exp = exp_q.pop_front();
    pop_event(got, vld);
    checks++;
    if (!vld || got !== exp || err_pulses !== exp_err) begin
      errors++;
      $display("FAIL timeout_recover: got valid=%b ev=%h errs=%0d, required valid=1 ev=%h errs=%0d", vld, got, err_pulses, exp, exp_err);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] got, exp;
    logic       vld;
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(8'h15 + 8'(i), 0, 0);
    checks++;
    if (ovf_pulses !== exp_ovf || ovf_wide !== 0) begin
      errors++;
      $display("FAIL overflow_drop: got pulses=%0d wide=%0d, required pulses=%0d wide=0", ovf_pulses, ovf_wide, exp_ovf);
    end
    // push into a full queue on the same edge as a pop: must be accepted
    send_bits(frame_bits(8'h1A, 0, 0), 10);
    kin = 1'b1;
    wait_cyc(HALF);
    kclk = 1'b0;
    wait_cyc(5);
    got = {ev_ext, ev_break, ev_code};
    vld = ev_valid;
    ev_ready = 1'b1;
    @(posedge clk50);
    #1 ev_ready = 1'b0;
    exp = exp_q.pop_front();
    model_byte(8'h1A);
    checks++;
    if (!vld || got !== exp) begin
      errors++;
      $display("FAIL full_pop_head: got valid=%b ev=%h, required valid=1 ev=%h", vld, got, exp);
    end
    wait_cyc(HALF);
    kclk = 1'b1;
    wait_cyc(4);
    checks++;
    if (ovf_pulses !== exp_ovf) begin
      errors++;
      $display("FAIL full_pop_no_ovf: got pulses=%0d, required %0d", ovf_pulses, exp_ovf);
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      pop_event(got, vld);
      checks++;
      if (!vld || got !== exp) begin
        errors++;
        $display("FAIL overflow_drain: got valid=%b ev=%h, required valid=1 ev=%h", vld, got, exp);
      end
    end
    @(negedge clk50);
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_empty: got valid=%b, required 0", ev_valid);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] got, exp;
    logic       vld;
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_bits(frame_bits(8'h72, 0, 0), 4);
    reset = 1'b0;
    @(posedge clk50);
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk50);
    checks++;
    if ({ev_valid, ev_ext, ev_break, ev_code, dir, frame_err, overflow} !== 16'h0) begin
      errors++;
      $display("FAIL midframe_reset: got valid=%b ext=%b brk=%b code=%h dir=%b err=%b ovf=%b, required all 0",
               ev_valid, ev_ext, ev_break, ev_code, dir, frame_err, overflow);
    end
    wait_cyc(HALF);
    send_frame(8'h75, 0, 0);
    exp = exp_q.pop_front();
    pop_event(got, vld);
    checks++;
    if (!vld || got !== exp || dir !== m_dir || err_pulses !== exp_err) begin
      errors++;
      $display("FAIL midframe_next: got valid=%b ev=%h dir=%b errs=%0d, required valid=1 ev=%h dir=%b errs=%0d",
               vld, got, dir, err_pulses, exp, m_dir, exp_err);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [12];
    logic [7:0] b;
    logic [9:0] got, exp;
    logic       vld;
    bit         bad, bad_par;
    int         npop;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'h29, 8'hE0, 8'hF0, 8'h74, 8'h6B};
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 11)];
      bad = ($urandom_range(0, 7) == 0);
      bad_par = ($urandom_range(0, 1) == 1);
      send_frame(b, bad && bad_par, bad && !bad_par);
      checks++;
      if (dir !== m_dir || err_pulses !== exp_err || ovf_pulses !== exp_ovf) begin
        errors++;
        $display("FAIL random_state_%0d: got dir=%b errs=%0d ovfs=%0d, required dir=%b errs=%0d ovfs=%0d",
                 it, dir, err_pulses, ovf_pulses, m_dir, exp_err, exp_ovf);
      end
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        exp = (exp_q.size() > 0) ? exp_q[0] : 10'h0;
        pop_event(got, vld);
        checks++;
        if (vld !== (exp_q.size() > 0) || (vld && got !== exp)) begin
          errors++;
          $display("FAIL random_pop_%0d: got valid=%b ev=%h, required valid=%b ev=%h", it, vld, got, exp_q.size() > 0, exp);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      pop_event(got, vld);
      checks++;
      if (!vld || got !== exp) begin
        errors++;
        $display("FAIL random_drain: got valid=%b ev=%h, required valid=1 ev=%h", vld, got, exp);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_arrows();
    test_frame_errors();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    test_random();
    checks++;
    if (err_wide !== 0 || ovf_wide !== 0) begin
      errors++;
      $display("FAIL pulse_width: got err_wide=%0d ovf_wide=%0d, required 0 and 0", err_wide, ovf_wide);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
